uart_rx: RTL

Receive half of the UART link: takes the asynchronous serial line, detects start bits, samples each bit mid-period with 3-point majority voting, and rebuilds the `2**WIDTH`-bit parallel word, LSB first. Optional even/odd parity and stop-bit checks run on every frame. A one-cycle valid strobe or error strobe is issued per frame. The block sits between the RX pad and the consumer of received bytes, mirroring the transmit-side serializer.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx_data_sampler.sv | 57 +++++
 rtl/uart_rx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// parity-type constants (common with the transmit side) and small helpers.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Majority of three samples of the same bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent, given the XOR of the data bits.
  function automatic logic parity_expected(input logic data_xor, input logic ptype);
    logic r;
    r = data_xor;
    case (ptype)
      PARITY_EVEN: r = data_xor;
      PARITY_ODD:  r = ~data_xor;
      default:     r = data_xor;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side and consumer-side signals of the UART receiver.
// slave = the receiver itself, master = whoever drives the line and
// consumes the received words.
interface uart_rx_if #(
  parameter int WIDTH = 3
);
  logic                  UART_RX_SerialData;
  logic                  UART_RX_ParityEn;
  logic                  UART_RX_ParityType;
  logic [2**WIDTH-1:0]   UART_RX_ParallelData;
  logic                  UART_RX_DataValid;
  logic                  UART_RX_ParityError;
  logic                  UART_RX_StopError;

  modport master (
    output UART_RX_SerialData, UART_RX_ParityEn, UART_RX_ParityType,
    input  UART_RX_ParallelData, UART_RX_DataValid, UART_RX_ParityError,
           UART_RX_StopError
  );

  modport slave (
    input  UART_RX_SerialData, UART_RX_ParityEn, UART_RX_ParityType,
    output UART_RX_ParallelData, UART_RX_DataValid, UART_RX_ParityError,
           UART_RX_StopError
  );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// Bit-timing engine: tick counter across one bit period and a 3-point
// majority vote centred on the middle of the bit.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,          // high while a frame is being received
  input  logic rx_s,         // synchronized serial line
  output logic bit_done,     // last tick of the bit period
  output logic sample_valid, // tick M+1: sampled_bit is the decided value
  output logic sampled_bit
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_S2   = TW'(M + 1);

  logic [TW-1:0] tick_q, tick_d;
  logic          s0_q, s0_d;
  logic          s1_q, s1_d;

  // Tick counter restarts at 0 whenever the receiver is idle so the first
  // active cycle of a frame is tick 0; the first two samples are held in
  // flops and the third is taken live so the vote lands on tick M+1.
  always_comb begin
    tick_d = tick_q;
    s0_d   = s0_q;
    s1_d   = s1_q;
    if (!run || (tick_q == T_LAST)) tick_d = '0;
    else                            tick_d = tick_q + TW'(1);
    if (run && (tick_q == T_S0)) s0_d = rx_s;
    if (run && (tick_q == T_S1)) s1_d = rx_s;
  end

  // Counter and sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
    end else begin
      tick_q <= tick_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
    end
  end

  assign bit_done     = run && (tick_q == T_LAST);
  assign sample_valid = run && (tick_q == T_S2);
  assign sampled_bit  = majority3(s0_q, s1_q, rx_s);

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: input synchronizer, frame FSM, shift register,
// parity/stop checks and registered result strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int OVERSAMPLE = 8
) (
  input  logic       UART_RX_CLK,
  input  logic       UART_RX_RST_ASYN,
  uart_rx_if.slave   bus
);
  localparam int N = 2**WIDTH;
  localparam logic [WIDTH-1:0] LAST_BIT = WIDTH'(N - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic             armed_q, armed_d;
  logic             parity_en_q, parity_en_d;
  logic             parity_type_q, parity_type_d;
  logic [WIDTH-1:0] bitcnt_q, bitcnt_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic             perr_q, perr_d;
  logic [N-1:0]     pdata_q, pdata_d;
  logic             dv_q, dv_d;
  logic             pe_q, pe_d;
  logic             se_q, se_d;

  logic run;
  logic bit_done;
  logic sample_valid;
  logic sampled_bit;

  assign run = (state_q != ST_IDLE);

  uart_rx_data_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk         (UART_RX_CLK),
    .rst         (UART_RX_RST_ASYN),
    .run         (run),
    .rx_s        (rx_s_q),
    .bit_done    (bit_done),
    .sample_valid(sample_valid),
    .sampled_bit (sampled_bit)
  );

  // Next-state and datapath logic; strobes default low so each is a single pulse.
  always_comb begin
    state_d       = state_q;
    sync1_d       = bus.UART_RX_SerialData;
    rx_s_d        = sync1_q;
    armed_d       = armed_q;
    parity_en_d   = parity_en_q;
    parity_type_d = parity_type_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    perr_d        = perr_q;
    pdata_d       = pdata_q;
    dv_d          = 1'b0;
    pe_d          = 1'b0;
    se_d          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A break (line stuck low) must not retrigger until the line idles high.
        if (rx_s_q) armed_d = 1'b1;
        if (!rx_s_q && armed_q) begin
          state_d       = ST_START;
          parity_en_d   = bus.UART_RX_ParityEn;
          parity_type_d = bus.UART_RX_ParityType;
          bitcnt_d      = '0;
          perr_d        = 1'b0;
        end
      end
      ST_START: begin
        if (sample_valid && sampled_bit) state_d = ST_IDLE;   // false start
        else if (bit_done)               state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sample_valid) shreg_d[bitcnt_q] = sampled_bit;
        if (bit_done) begin
          if (bitcnt_q == LAST_BIT) state_d = parity_en_q ? ST_PARITY : ST_STOP;
          else                      bitcnt_d = bitcnt_q + WIDTH'(1);
        end
      end
      ST_PARITY: begin
        if (sample_valid)
          perr_d = (parity_expected(^shreg_q, parity_type_q) != sampled_bit);
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Decide mid stop bit and leave at once so a following start bit is caught.
        if (sample_valid) begin
          state_d = ST_IDLE;
          if (!sampled_bit) begin
            se_d    = 1'b1;
            armed_d = 1'b0;
          end else if (perr_q) begin
            pe_d = 1'b1;
          end else begin
            dv_d    = 1'b1;
            pdata_d = shreg_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge UART_RX_CLK or posedge UART_RX_RST_ASYN) begin
    if (UART_RX_RST_ASYN) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  // Synchronizer, frame datapath and output registers.
  always_ff @(posedge UART_RX_CLK or posedge UART_RX_RST_ASYN) begin
    if (UART_RX_RST_ASYN) begin
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      armed_q       <= 1'b1;
      parity_en_q   <= 1'b0;
      parity_type_q <= PARITY_EVEN;
      bitcnt_q      <= '0;
      shreg_q       <= '0;
      perr_q        <= 1'b0;
      pdata_q       <= '0;
      dv_q          <= 1'b0;
      pe_q          <= 1'b0;
      se_q          <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      rx_s_q        <= rx_s_d;
      armed_q       <= armed_d;
      parity_en_q   <= parity_en_d;
      parity_type_q <= parity_type_d;
      bitcnt_q      <= bitcnt_d;
      shreg_q       <= shreg_d;
      perr_q        <= perr_d;
      pdata_q       <= pdata_d;
      dv_q          <= dv_d;
      pe_q          <= pe_d;
      se_q          <= se_d;
    end
  end

  assign bus.UART_RX_ParallelData = pdata_q;
  assign bus.UART_RX_DataValid    = dv_q;
  assign bus.UART_RX_ParityError  = pe_q;
  assign bus.UART_RX_StopError    = se_q;

endmodule
